tdm_demultiplexer: RTL and testbench

- Receive end of the 4:1 channel-select path: takes a serial stream in which consecutive valid bits belong to channel slots 0..CH-1 (slot i is the bit a multiplexer drives with select = i).
- Routes each bit to its own channel and presents the whole frame as a parallel word.
- Frame boundaries are marked by frame_start; loss of alignment is detected and flagged.
- Sits downstream of the mux/serial link, feeding per-channel logic.

---
 rtl/tdm_if.sv | 23 ++
 rtl/tdm_demultiplexer.sv | 67 ++++++
 tb/tb_tdm_demultiplexer.sv | 102 ++++++++++
 3 files changed

// File: rtl/tdm_if.sv
// tdm_if: serial TDM input and parallel frame output between link and demultiplexer.
interface tdm_if #(
    parameter int CH = 4,
    parameter int SW = 2
) ();
    logic          din;
    logic          din_valid;
    logic          frame_start;
    logic          err_clr;
    logic [CH-1:0] dout;
    logic          dout_valid;
    logic [SW-1:0] slot;
    logic          busy;
    logic          sync_err;
    modport master (
        output din, din_valid, frame_start, err_clr,
        input  dout, dout_valid, slot, busy, sync_err
    );
    modport slave (
        input  din, din_valid, frame_start, err_clr,
        output dout, dout_valid, slot, busy, sync_err
    );
endinterface

// File: rtl/tdm_demultiplexer.sv
// tdm_demultiplexer: routes serial slot bits into a parallel CH-bit frame with alignment checking.
module tdm_demultiplexer #(
    parameter int CH = 4,
    parameter int SW = 2
) (
    input logic   clk,
    input logic   rst,
    tdm_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;
    logic [0:0]    state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [CH-1:0] shadow_q, shadow_d;
    logic [CH-1:0] dout_q, dout_d;
    logic          dv_q, dv_d;
    logic          err_q, err_d;
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        dout_d   = dout_q;
        dv_d     = 1'b0;
        err_d    = err_q;
        if (bus.din_valid) begin
            err_d = err_q & ~bus.err_clr;
            if (bus.frame_start) begin
                // An early start aborts the partial frame and restarts at slot 0.
                err_d       = err_d | (state_q == RECV);
                shadow_d    = '0;
                shadow_d[0] = bus.din;
                slot_d      = SW'(1);
                state_d     = RECV;
            end else if (state_q == RECV) begin
                shadow_d[slot_q] = bus.din;
                slot_d           = slot_q + SW'(1);
                if (slot_q == SW'(CH-1)) begin
                    dout_d  = shadow_d;
                    dv_d    = 1'b1;
                    state_d = IDLE;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            shadow_q <= '0;
            dout_q   <= '0;
            dv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            dout_q   <= dout_d;
            dv_q     <= dv_d;
            err_q    <= err_d;
        end
    end
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.slot       = slot_q;
    assign bus.busy       = (state_q == RECV);
    assign bus.sync_err   = err_q;
endmodule

// File: tb/tb_tdm_demultiplexer.sv
// tb_tdm_demultiplexer: directed vector table plus hand sequences for the CH=4 demultiplexer.
module tb_tdm_demultiplexer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    tdm_if #(.CH(4), .SW(2)) bus ();
    tdm_demultiplexer #(.CH(4), .SW(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic       r, v, fs, d, clr;
        logic [3:0] dout;
        logic       dv;
        logic [1:0] slot;
        logic       busy, err;
    } vec_t;
    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;
    function automatic vec_t mk(logic r, v, fs, d, clr, logic [3:0] dout, logic dv,
                                logic [1:0] slot, logic busy, err);
        vec_t x;
        x.r = r; x.v = v; x.fs = fs; x.d = d; x.clr = clr;
        x.dout = dout; x.dv = dv; x.slot = slot; x.busy = busy; x.err = err;
        return x;
    endfunction
    task automatic apply(string name, vec_t x);
        rst = x.r; bus.din_valid = x.v; bus.frame_start = x.fs; bus.din = x.d; bus.err_clr = x.clr;
        @(posedge clk);
        #1;
        n_vec++;
        if ({bus.dout, bus.dout_valid, bus.slot, bus.busy, bus.sync_err} !==
            {x.dout, x.dv, x.slot, x.busy, x.err}) begin
            n_bad++;
            $display("FAIL %s: got dout=%b dv=%b slot=%0d busy=%b err=%b, want dout=%b dv=%b slot=%0d busy=%b err=%b",
                     name, bus.dout, bus.dout_valid, bus.slot, bus.busy, bus.sync_err,
                     x.dout, x.dv, x.slot, x.busy, x.err);
        end
    endtask
    initial begin
        rst = 1'b1; bus.din_valid = 1'b0; bus.frame_start = 1'b0; bus.din = 1'b0; bus.err_clr = 1'b0;
        //            r  v  fs d  clr dout     dv slot busy err
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'b0000, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b0000, 0, 3, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0101, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0101, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'b0101, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b0101, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'b0101, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'b0101, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0101, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0101, 0, 3, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b1011, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b1011, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'b1011, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b1011, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b1011, 0, 3, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b1000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'b1000, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b1000, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b1000, 0, 3, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b1111, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b1111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'b1111, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'b1111, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b1111, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'b1111, 0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b1111, 0, 2, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b1111, 0, 3, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0110, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0110, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 1, 4'b0110, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'b0110, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 4'b0110, 0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b0110, 0, 2, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b0110, 0, 3, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b1110, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 1, 4'b1110, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b1110, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b1110, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'b1110, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b1110, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b1110, 0, 3, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'b1110, 0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b1110, 0, 2, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b1110, 0, 3, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b1010, 1, 0, 0, 1));
        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);
        // Reset mid-frame: partial frame dropped, sticky error and dout cleared.
        apply("rst_mid_a", mk(0, 1, 1, 1, 0, 4'b1010, 0, 1, 1, 1));
        apply("rst_mid_b", mk(0, 1, 0, 1, 0, 4'b1010, 0, 2, 1, 1));
        apply("rst_mid_c", mk(1, 1, 0, 1, 0, 4'b0000, 0, 0, 0, 0));
        apply("rst_mid_d", mk(0, 1, 0, 1, 0, 4'b0000, 0, 0, 0, 0));
        apply("post_rst_0", mk(0, 1, 1, 1, 0, 4'b0000, 0, 1, 1, 0));
        apply("post_rst_1", mk(0, 1, 0, 0, 0, 4'b0000, 0, 2, 1, 0));
        apply("post_rst_2", mk(0, 1, 0, 0, 0, 4'b0000, 0, 3, 1, 0));
        apply("post_rst_3", mk(0, 1, 0, 1, 0, 4'b1001, 1, 0, 0, 0));
        apply("post_rst_hold", mk(0, 0, 0, 0, 0, 4'b1001, 0, 0, 0, 0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
